// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX operand-capture register downstream of the register file.
// Resolves operands (r0 forced to zero, same-cycle writeback bypass), detects
// load-use hazards, and holds one instruction under valid/ready flow control
// with flush.
// Optional feature macro: IDEX_HAZARD_CNT_EN adds a saturating hz_count output
// that counts inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned CTRL_W      = 8,
    parameter int unsigned MEMREAD_BIT = 0
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              wb_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_a,
    output logic [31:0]       out_b,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef IDEX_HAZARD_CNT_EN
    ,
    output logic [31:0]       hz_count
`endif
);

    logic              valid_q, valid_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hz;
    logic        capture;

    // Operand resolution: r0 reads zero, otherwise a same-cycle writeback
    // wins over the stale register file value.
    always_comb begin
        op_a = a;
        if (rs == 5'd0) begin
            op_a = '0;
        end else if (wb_write && (wb_rd == rs)) begin
            op_a = wb_data;
        end
        op_b = b;
        if (rt == 5'd0) begin
            op_b = '0;
        end else if (wb_write && (wb_rd == rt)) begin
            op_b = wb_data;
        end
    end

    // Load-use hazard and input handshake; flush blocks acceptance outright.
    always_comb begin
        hz = valid_q && ctrl_q[MEMREAD_BIT] && (rd_q != 5'd0) && in_valid &&
             ((rd_q == rs) || (rd_q == rt));
        in_ready = !flush && !hz && (!valid_q || out_ready);
        capture  = in_valid && in_ready;
    end

    // Next-state: flush empties the slot, capture loads it, a drain empties
    // it, otherwise everything holds.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            a_d     = op_a;
            b_d     = op_b;
            imm_d   = {{16{imm[15]}}, imm};
            rs_d    = rs;
            rt_d    = rt;
            rd_d    = rd;
            ctrl_d  = ctrl;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_imm   = imm_q;
    assign out_rs    = rs_q;
    assign out_rt    = rt_q;
    assign out_rd    = rd_q;
    assign out_ctrl  = ctrl_q;

`ifdef IDEX_HAZARD_CNT_EN
    logic [31:0] hz_cnt_q, hz_cnt_d;

    // Bubble counter: one count per inserted bubble, saturating.
    always_comb begin
        hz_cnt_d = hz_cnt_q;
        if (hz && out_ready && (hz_cnt_q != 32'hFFFF_FFFF)) begin
            hz_cnt_d = hz_cnt_q + 32'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            hz_cnt_q <= '0;
        end else begin
            hz_cnt_q <= hz_cnt_d;
        end
    end

    assign hz_count = hz_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        Clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [7:0]  ctrl;
    logic [31:0] a, b;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_imm;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [7:0]  out_ctrl;
`ifdef IDEX_HAZARD_CNT_EN
    logic [31:0] hz_count;
`endif

    int vectors = 0;
    int errors  = 0;

    id_ex_stage #(
        .CTRL_W      (8),
        .MEMREAD_BIT (0)
    ) dut (
        .Clk       (Clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .wb_write  (wb_write),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_imm   (out_imm),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_rd    (out_rd),
        .out_ctrl  (out_ctrl)
`ifdef IDEX_HAZARD_CNT_EN
        ,
        .hz_count  (hz_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] s, input logic [31:0] va, input logic [4:0] t,
                         input logic [31:0] vb, input logic [4:0] d, input logic [15:0] im,
                         input logic [7:0] c);
        in_valid = 1'b1;
        rs = s; a = va; rt = t; b = vb; rd = d; imm = im; ctrl = c;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; rs = '0; rt = '0; rd = '0; imm = '0; ctrl = '0;
        a = '0; b = '0; wb_write = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
`ifdef IDEX_HAZARD_CNT_EN
        chk("rst_hzcnt", hz_count, 32'd0);
`endif

        // First capture after reset release, negative immediate.
        rst = 1'b1;
        out_ready = 1'b1;
        instr(5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 16'h8001, 8'h00);
        #1;
        chk("empty_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("cap_valid", 32'(out_valid), 32'd1);
        chk("cap_a", out_a, 32'h11);
        chk("cap_b", out_b, 32'h22);
        chk("cap_imm", out_imm, 32'hFFFF_8001);
        chk("cap_rs", 32'(out_rs), 32'd3);
        chk("cap_rt", 32'(out_rt), 32'd4);
        chk("cap_rd", 32'(out_rd), 32'd9);

        // Same-cycle writeback bypass on rs, positive immediate.
        instr(5'd5, 32'hAAAA, 5'd6, 32'hBBBB, 5'd1, 16'h7FFF, 8'h00);
        wb_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        chk("byp_a", out_a, 32'h1234);
        chk("byp_b", out_b, 32'hBBBB);
        chk("byp_imm", out_imm, 32'h0000_7FFF);

        // r0 reads zero even with a writeback targeting r0.
        instr(5'd0, 32'h5555, 5'd8, 32'hCCCC, 5'd1, 16'h0001, 8'h00);
        wb_rd = 5'd0; wb_data = 32'h9999;
        tick();
        chk("r0_a", out_a, 32'd0);
        chk("r0_b", out_b, 32'hCCCC);

        // Bypass on rt.
        instr(5'd2, 32'h1, 5'd8, 32'hCCCC, 5'd1, 16'h0002, 8'h00);
        wb_rd = 5'd8; wb_data = 32'hDEAD;
        tick();
        chk("bypb_a", out_a, 32'h1);
        chk("bypb_b", out_b, 32'hDEAD);
        wb_write = 1'b0;

        // Backpressure for three cycles: nothing accepted, outputs stable.
        out_ready = 1'b0;
        instr(5'd10, 32'hA0, 5'd11, 32'hB0, 5'd12, 16'h0003, 8'h02);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_a", out_a, 32'h1);
            chk("bp_b", out_b, 32'hDEAD);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_cap_a", out_a, 32'hA0);
        chk("bp_cap_ctrl", 32'(out_ctrl), 32'h02);

        // Load-use: load to r7, then a consumer reading r7 through rt.
        instr(5'd1, 32'h10, 5'd2, 32'h20, 5'd7, 16'h0004, 8'h01);
        tick();
        chk("ld_ctrl", 32'(out_ctrl), 32'h01);
        chk("ld_rd", 32'(out_rd), 32'd7);
        instr(5'd3, 32'h30, 5'd7, 32'h77, 5'd12, 16'h0005, 8'h00);
        #1;
        chk("lu_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("lu_cap_valid", 32'(out_valid), 32'd1);
        chk("lu_cap_b", out_b, 32'h77);
        chk("lu_cap_rt", 32'(out_rt), 32'd7);
`ifdef IDEX_HAZARD_CNT_EN
        chk("lu_hzcnt", hz_count, 32'd1);
`endif

        // Flush while full: input refused even with out_ready, then accepted.
        instr(5'd4, 32'h44, 5'd5, 32'h55, 5'd6, 16'h0006, 8'h00);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        #1;
        chk("fl_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("fl_cap_valid", 32'(out_valid), 32'd1);
        chk("fl_cap_a", out_a, 32'h44);
        chk("fl_cap_b", out_b, 32'h55);

        // Asynchronous reset mid-cycle while full.
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_a", out_a, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-capture stage directly downstream of the register file.
- Takes the decoded instruction fields plus the register file's combinational read ports (a, b) and produces the registered ID/EX operand bundle consumed by the execute stage.
- Provides same-cycle writeback bypass: register file writes land on the clock edge, so a same-cycle read returns the stale value.
- Forces register 0 to read as zero, detects load-use hazards, and implements valid/ready flow control with flush.

Parameters:
- CTRL_W, 8, width of the opaque control bundle passed from decode to execute.
- MEMREAD_BIT, 0, index within ctrl marking a load instruction; used for load-use detection.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- rs, rt, rd  in  5 each  register specifiers of the decoding instruction.
- imm  in  16  raw immediate field.
- ctrl  in  CTRL_W  decoded control bundle.
- a, b  in  32 each  register file read data for rs and rt.
- wb_write, wb_rd, wb_data  in  1/5/32  writeback port, the same values driven into the register file this cycle.
- flush  in  1  kill the held instruction (branch/jump redirect).
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_a, out_b  out  32 each  resolved operands.
- out_imm  out  32  sign-extended immediate.
- out_rs, out_rt, out_rd  out  5 each  registered specifiers.
- out_ctrl  out  CTRL_W  registered control.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; all other out_* = 0. in_ready is combinational and reads 1 while in reset-released EMPTY.
- States (held in out_valid): EMPTY (0) and FULL (1).
- Operand resolution (combinational, before capture), for rs:
  - rs==0 -> 0.
  - else wb_write && wb_rd==rs -> wb_data.
  - else a.
  - Same rules for rt/b. wb_rd==0 never bypasses.
- Load-use hazard (combinational): hz = out_valid && out_ctrl[MEMREAD_BIT] && out_rd!=0 && in_valid && (out_rd==rs || out_rd==rt).
- in_ready = !flush && !hz && (!out_valid || out_ready).
- Capture (in_valid && in_ready): next cycle out_valid=1; out_* = resolved operands, sign-extended imm (bit 15 replicated into 31:16), rs/rt/rd, ctrl.
- Drain (out_valid && out_ready && no capture): next cycle out_valid=0.
- Hold (out_valid && !out_ready): all out_* stable.
- Bubble: when hz && out_ready, the load leaves and the slot goes EMPTY (out_valid=0 for exactly one cycle). The consumer is captured the following cycle; the one-cycle bubble covers load latency, and execute/memory forwarding supplies the value.
- Flush: highest priority; next cycle out_valid=0. The input is not accepted that cycle (in_ready=0), whether or not out_ready is asserted.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 per cycle with no hazards.
- out_* data fields are don't-care when out_valid=0 but must not be X after reset.

Optional Feature:
- IDEX_HAZARD_CNT_EN defined:
  - Adds output hz_count (32 bits), reset to 0.
  - Increments by 1 on each cycle with hz && out_ready (each inserted bubble).
  - Saturates at 32'hFFFFFFFF; unaffected by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then release with in_valid=1, rs=3, rt=4, a=0x11, b=0x22, imm=0x8001, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22, out_imm=0xFFFF8001.
- Same-cycle bypass: rs=5, a=0xAAAA, wb_write=1, wb_rd=5, wb_data=0x1234 -> out_a=0x1234. Repeat with wb_rd=0, rs=0 -> out_a=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable; on out_ready=1 the next instruction is captured the following cycle.
- Load-use: held load with rd=7 (ctrl[0]=1), incoming rt=7, out_ready=1 -> in_ready=0, one cycle out_valid=0, then consumer captured; hz_count=1 when enabled.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, input not consumed (in_ready=0); the same instruction is accepted the cycle after.
- Asynchronous reset asserted mid-stream while FULL -> out_valid drops to 0 immediately, without waiting for Clk.
